// File: rtl/demux_pkg.sv
// demux_pkg: shared widths, select encodings and slot state type for the 1-to-2 stream demux
package demux_pkg;
  localparam int DEMUX_WIDTH_DEF = 8;
  localparam int CNT_W = 16;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
  typedef enum logic [0:0] {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-word output register with EMPTY/FULL state; transfer counter when DEMUX_CNT_EN is defined
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);
  slot_state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic drain;
  assign drain = (state_q == SLOT_FULL) && ready;
  // a load always wins; load only happens when the slot is empty or draining, so the word is never lost
  always_comb begin
    state_d = load ? SLOT_FULL : (drain ? SLOT_EMPTY : state_q);
    data_d  = load ? d : data_q;
  end
  // slot register; data is kept after drain, only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end
  assign q     = data_q;
  assign valid = (state_q == SLOT_FULL);
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // count output transfers, wrapping naturally at the counter width
  always_comb cnt_d = drain ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
`endif
endmodule

// File: rtl/onetotwo_demux_stream.sv
// onetotwo_demux_stream: registered 1-to-2 valid/ready demux; CNT_A/CNT_B ports exist only with DEMUX_CNT_EN
module onetotwo_demux_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             S,
  input  logic [WIDTH-1:0] Z,
  input  logic             Z_VALID,
  output logic             Z_READY,
  output logic [WIDTH-1:0] A,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] B,
  output logic             B_VALID,
  input  logic             B_READY
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
`endif
);
  logic load_a, load_b;
  // ready reflects only the selected slot, so a stalled branch never blocks the other
  always_comb begin
    Z_READY = (S == SEL_A) ? (!A_VALID || A_READY) : (!B_VALID || B_READY);
    load_a  = Z_VALID && Z_READY && (S == SEL_A);
    load_b  = Z_VALID && Z_READY && (S == SEL_B);
  end
  demux_out_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk(CLK), .rst_n(RST_N), .load(load_a), .d(Z), .ready(A_READY), .q(A), .valid(A_VALID)
`ifdef DEMUX_CNT_EN
    , .cnt(CNT_A)
`endif
  );
  demux_out_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk(CLK), .rst_n(RST_N), .load(load_b), .d(Z), .ready(B_READY), .q(B), .valid(B_VALID)
`ifdef DEMUX_CNT_EN
    , .cnt(CNT_B)
`endif
  );
endmodule

// File: tb/tb_onetotwo_demux_stream.sv
// tb_onetotwo_demux_stream: directed vector table plus reset and counter-wrap sequences
module tb_onetotwo_demux_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s = 1'b0;
  logic [7:0] z = 8'h00;
  logic zv = 1'b0;
  logic zr;
  logic [7:0] a, b;
  logic av, bv;
  logic ar = 1'b1;
  logic br = 1'b1;
  int checks = 0;
  int failures = 0;
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif
  always #5 clk = ~clk;
  onetotwo_demux_stream dut (
    .CLK(clk), .RST_N(rst_n), .S(s), .Z(z), .Z_VALID(zv), .Z_READY(zr),
    .A(a), .A_VALID(av), .A_READY(ar), .B(b), .B_VALID(bv), .B_READY(br)
`ifdef DEMUX_CNT_EN
    , .CNT_A(cnt_a), .CNT_B(cnt_b)
`endif
  );
  typedef struct {
    logic s; logic [7:0] z; logic zv; logic ar; logic br;
    logic zr; logic av; logic [7:0] a; logic bv; logic [7:0] b;
  } vec_t;
  vec_t v[15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    v[0]  = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
    v[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22};
    v[2]  = '{1'b0, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h22};
    v[3]  = '{1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
    v[4]  = '{1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b0, 8'h22};
    v[5]  = '{1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 8'h22};
    v[6]  = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h66};
    v[7]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 8'h77};
    v[8]  = '{1'b0, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 8'h77};
    v[9]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h01};
    v[10] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h02};
    v[11] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h03};
    v[12] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 8'h04};
    v[13] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 8'h04};
    v[14] = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 8'h04};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 32'(av), 32'h0);
    chk("rst_b_valid", 32'(bv), 32'h0);
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_b", 32'(b), 32'h0);
    chk("rst_z_ready", 32'(zr), 32'h1);
`ifdef DEMUX_CNT_EN
    chk("rst_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_cnt_b", 32'(cnt_b), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      s = v[i].s; z = v[i].z; zv = v[i].zv; ar = v[i].ar; br = v[i].br;
      #1;
      chk($sformatf("v%0d_z_ready", i), 32'(zr), 32'(v[i].zr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_valid", i), 32'(av), 32'(v[i].av));
      chk($sformatf("v%0d_a", i), 32'(a), 32'(v[i].a));
      chk($sformatf("v%0d_b_valid", i), 32'(bv), 32'(v[i].bv));
      chk($sformatf("v%0d_b", i), 32'(b), 32'(v[i].b));
      @(negedge clk);
    end
    s = 1'b0; z = 8'hAB; zv = 1'b1; ar = 1'b0; br = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_load_a_valid", 32'(av), 32'h1);
    chk("mid_load_a", 32'(a), 32'hAB);
    zv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 32'(av), 32'h0);
    chk("mid_rst_a", 32'(a), 32'h0);
    chk("mid_rst_b_valid", 32'(bv), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_a_valid", 32'(av), 32'h0);
    chk("post_rst_a", 32'(a), 32'h0);
`ifdef DEMUX_CNT_EN
    @(negedge clk);
    s = 1'b0; zv = 1'b1; ar = 1'b1; br = 1'b1;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    zv = 1'b0;
    @(posedge clk);
    #1;
    chk("cnt_a_wrap", 32'(cnt_a), 32'h1);
    chk("cnt_b_hold", 32'(cnt_b), 32'h0);
    chk("cnt_a_drained", 32'(av), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
